// File: rtl/rob_param_pkg.sv
// Shared definitions for the reorder buffer: entry kinds, default data width, null register.
package rob_param_pkg;

  localparam int ROB_XLEN = 32;

  typedef enum logic [1:0] {
    ROB_ALU  = 2'd0,
    ROB_BR   = 2'd1,
    ROB_ST   = 2'd2,
    ROB_JALR = 2'd3
  } robKind_e;

  localparam logic [4:0] RD_NONE = 5'd0;

endpackage

// File: rtl/rob_wb_merge.sv
// Priority decode of the NUM_WB writeback channels into per-entry set strobes and values.
module rob_wb_merge
  import rob_param_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = 2,
  parameter int XLEN   = ROB_XLEN
) (
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_val_i,
  output logic [DEPTH-1:0]        set_o,
  output logic [DEPTH*XLEN-1:0]   val_o
);

  // Later channels overwrite earlier ones, so the highest-numbered hit wins.
  always_comb begin
    set_o = '0;
    val_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid_i[k] && (wb_idx_i[k*IDX_W +: IDX_W] == IDX_W'(e))) begin
          set_o[e]               = 1'b1;
          val_o[e*XLEN +: XLEN]  = wb_val_i[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order alloc, NUM_WB writeback channels, one retire per cycle.
// Optional macro ROB_BYPASS_EN forwards same-cycle writebacks to the decoder operand lookups.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = 2,
  parameter int XLEN   = ROB_XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  input  logic [1:0]              alloc_kind,
  input  logic [4:0]              alloc_rd,
  input  logic                    alloc_done,
  input  logic                    alloc_pred,
  input  logic [XLEN-1:0]         alloc_val,
  output logic [IDX_W-1:0]        alloc_idx,
  output logic                    rob_full,
  input  logic [IDX_W-1:0]        rs1_idx,
  input  logic [IDX_W-1:0]        rs2_idx,
  output logic                    rs1_ready,
  output logic                    rs2_ready,
  output logic [XLEN-1:0]         rs1_val,
  output logic [XLEN-1:0]         rs2_val,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*XLEN-1:0]  wb_val,
  output logic                    commit_valid,
  output logic [IDX_W-1:0]        commit_idx,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_val,
  output logic                    store_go,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_pc
);

  logic [DEPTH-1:0]      ready_q, misp_q, pred_q;
  robKind_e              kind_q [DEPTH];
  logic [4:0]            rd_q   [DEPTH];
  logic [XLEN-1:0]       val_q  [DEPTH];
  logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]        count_q, count_d;
  logic                  flush_q;
  logic [XLEN-1:0]       flushPc_q, jalrTgt_q;
  logic [DEPTH-1:0]      wbSet;
  logic [DEPTH*XLEN-1:0] wbSetVal;
  logic                  headRetiring, retireFire, allocFire, headMispred;
  robKind_e              headKind;

  rob_wb_merge #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .NUM_WB(NUM_WB),
    .XLEN  (XLEN)
  ) u_merge (
    .wb_valid_i(wb_valid),
    .wb_idx_i  (wb_idx),
    .wb_val_i  (wb_val),
    .set_o     (wbSet),
    .val_o     (wbSetVal)
  );

  // Entries behind a mispredict must not retire while the flush is being signalled.
  assign headKind     = kind_q[head_q];
  assign headRetiring = !flush_q && (count_q != '0) && ready_q[head_q];
  assign retireFire   = rdy && headRetiring;
  assign headMispred  = (headKind == ROB_JALR) || ((headKind == ROB_BR) && misp_q[head_q]);
  // rob_full's DEPTH-1 term is a look-ahead stall; the entry itself is accepted while space remains.
  assign allocFire    = rdy && alloc_valid && (count_q != (IDX_W+1)'(DEPTH));

  always_comb begin
    head_d  = retireFire ? head_q + 1'b1 : head_q;
    tail_d  = allocFire ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (IDX_W+1)'(allocFire) - (IDX_W+1)'(retireFire);
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && flush_q)) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ready_q   <= '0;
      flush_q   <= 1'b0;
      flushPc_q <= '0;
      jalrTgt_q <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= retireFire && headMispred;
      if (retireFire && headMispred) begin
        flushPc_q <= (headKind == ROB_JALR) ? jalrTgt_q : val_q[head_q];
      end
      // Branch results only carry the taken bit; the stored value stays the alternate pc.
      for (int e = 0; e < DEPTH; e++) begin
        if (wbSet[e]) begin
          ready_q[e] <= 1'b1;
          if (kind_q[e] == ROB_BR) begin
            misp_q[e] <= pred_q[e] ^ wbSetVal[e*XLEN];
          end else begin
            val_q[e] <= wbSetVal[e*XLEN +: XLEN];
            if (kind_q[e] == ROB_JALR) begin
              jalrTgt_q <= wbSetVal[e*XLEN +: XLEN];
            end
          end
        end
      end
      if (allocFire) begin
        kind_q[tail_q]  <= robKind_e'(alloc_kind);
        rd_q[tail_q]    <= alloc_rd;
        pred_q[tail_q]  <= alloc_pred;
        val_q[tail_q]   <= alloc_val;
        ready_q[tail_q] <= alloc_done;
        misp_q[tail_q]  <= 1'b0;
      end
    end
  end

  assign alloc_idx    = tail_q;
  assign rob_full     = (count_q == (IDX_W+1)'(DEPTH)) ||
                        ((count_q == (IDX_W+1)'(DEPTH-1)) && alloc_valid && !headRetiring);
  assign commit_valid = retireFire && (rd_q[head_q] != RD_NONE) &&
                        (headKind != ROB_BR) && (headKind != ROB_ST);
  assign commit_idx   = head_q;
  assign commit_rd    = rd_q[head_q];
  assign commit_val   = val_q[head_q];
  assign store_go     = !flush_q && (count_q != '0) && (headKind == ROB_ST);
  assign flush        = flush_q;
  assign flush_pc     = flushPc_q;

  always_comb begin
    rs1_ready = ready_q[rs1_idx];
    rs1_val   = ready_q[rs1_idx] ? val_q[rs1_idx] : XLEN'(rs1_idx);
    rs2_ready = ready_q[rs2_idx];
    rs2_val   = ready_q[rs2_idx] ? val_q[rs2_idx] : XLEN'(rs2_idx);
`ifdef ROB_BYPASS_EN
    // Walk channels downward so the lowest-numbered hit is applied last and wins.
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == rs1_idx)) begin
        rs1_ready = 1'b1;
        rs1_val   = wb_val[k*XLEN +: XLEN];
      end
      if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == rs2_idx)) begin
        rs2_ready = 1'b1;
        rs2_val   = wb_val[k*XLEN +: XLEN];
      end
    end
`endif
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=16, NUM_WB=2, XLEN=32): table-driven cycles plus corner sequences.
module tb_rob_param;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        allocValid;
  logic [1:0]  allocKind;
  logic [4:0]  allocRd;
  logic        allocDone;
  logic        allocPred;
  logic [31:0] allocVal;
  logic [3:0]  allocIdx;
  logic        robFull;
  logic [3:0]  rs1Idx, rs2Idx;
  logic        rs1Ready, rs2Ready;
  logic [31:0] rs1Val, rs2Val;
  logic [1:0]  wbValid;
  logic [7:0]  wbIdx;
  logic [63:0] wbVal;
  logic        commitValid;
  logic [3:0]  commitIdx;
  logic [4:0]  commitRd;
  logic [31:0] commitVal;
  logic        storeGo;
  logic        flush;
  logic [31:0] flushPc;

  int checks;
  int failures;

  rob_param dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alloc_valid (allocValid),
    .alloc_kind  (allocKind),
    .alloc_rd    (allocRd),
    .alloc_done  (allocDone),
    .alloc_pred  (allocPred),
    .alloc_val   (allocVal),
    .alloc_idx   (allocIdx),
    .rob_full    (robFull),
    .rs1_idx     (rs1Idx),
    .rs2_idx     (rs2Idx),
    .rs1_ready   (rs1Ready),
    .rs2_ready   (rs2Ready),
    .rs1_val     (rs1Val),
    .rs2_val     (rs2Val),
    .wb_valid    (wbValid),
    .wb_idx      (wbIdx),
    .wb_val      (wbVal),
    .commit_valid(commitValid),
    .commit_idx  (commitIdx),
    .commit_rd   (commitRd),
    .commit_val  (commitVal),
    .store_go    (storeGo),
    .flush       (flush),
    .flush_pc    (flushPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle and the combinational outputs expected before the edge.
  typedef struct {
    logic        av;
    logic [1:0]  ak;
    logic [4:0]  ard;
    logic        adone;
    logic        apred;
    logic [31:0] aval;
    logic [1:0]  wbv;
    logic [3:0]  wi0;
    logic [31:0] wv0;
    logic [3:0]  wi1;
    logic [31:0] wv1;
    logic [3:0]  rs1;
    logic [3:0]  eIdx;
    logic        eFull;
    logic        eCv;
    logic [4:0]  eCrd;
    logic [31:0] eCval;
    logic        eRdy;
    logic [31:0] eRval;
    logic        eFlush;
    logic [31:0] eFpc;
    logic        eSgo;
  } vec_t;

  vec_t tbl[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    allocValid = 1'b0; allocKind = 2'd0; allocRd = 5'd0; allocDone = 1'b0;
    allocPred = 1'b0; allocVal = 32'd0; wbValid = 2'b00; wbIdx = 8'd0; wbVal = 64'd0;
    rs1Idx = 4'd0; rs2Idx = 4'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    allocValid = v.av;  allocKind = v.ak;  allocRd = v.ard;  allocDone = v.adone;
    allocPred  = v.apred; allocVal = v.aval;
    wbValid = v.wbv;
    wbIdx   = {v.wi1, v.wi0};
    wbVal   = {v.wv1, v.wv0};
    rs1Idx  = v.rs1;
    rs2Idx  = 4'd0;
  endtask

  task automatic setWb(input int ch, input logic [3:0] idx, input logic [31:0] val);
    wbValid[ch]          = 1'b1;
    wbIdx[ch*4 +: 4]     = idx;
    wbVal[ch*32 +: 32]   = val;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    clearInputs();
    rdy = 1'b1;
    rst = 1'b1;

    //  av ak rd dn pr aval       wbv   wi0 wv0      wi1 wv1      rs1  eIdx Fu Cv Crd Cval      Rdy Rval      Fl Fpc       Sgo
    tbl[0]  = '{1, 0, 5, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    0,   0, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0};
    tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,     2'b10, 0, 32'h0,    0, 32'h1234, 1,   1, 0, 0, 0, 32'h0,    0, 32'h1,    0, 32'h0,    0};
    tbl[2]  = '{0, 0, 0, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    0,   1, 0, 1, 5, 32'h1234, 1, 32'h1234, 0, 32'h0,    0};
    tbl[3]  = '{1, 1, 0, 0, 0, 32'h80,    2'b00, 0, 32'h0,    0, 32'h0,    2,   1, 0, 0, 0, 32'h0,    0, 32'h2,    0, 32'h0,    0};
    tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,     2'b01, 1, 32'h1,    0, 32'h0,    3,   2, 0, 0, 0, 32'h0,    0, 32'h3,    0, 32'h0,    0};
    tbl[5]  = '{1, 0, 7, 0, 0, 32'h55,    2'b00, 0, 32'h0,    0, 32'h0,    1,   2, 0, 0, 0, 32'h0,    1, 32'h80,   0, 32'h0,    0};
    tbl[6]  = '{1, 0, 3, 1, 0, 32'h66,    2'b00, 0, 32'h0,    0, 32'h0,    2,   3, 0, 0, 0, 32'h0,    0, 32'h2,    1, 32'h80,   0};
    tbl[7]  = '{0, 0, 0, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    2,   0, 0, 0, 0, 32'h0,    0, 32'h2,    0, 32'h0,    0};
    tbl[8]  = '{1, 1, 0, 0, 1, 32'h90,    2'b00, 0, 32'h0,    0, 32'h0,    3,   0, 0, 0, 0, 32'h0,    0, 32'h3,    0, 32'h0,    0};
    tbl[9]  = '{0, 0, 0, 0, 0, 32'h0,     2'b10, 0, 32'h0,    0, 32'h1,    3,   1, 0, 0, 0, 32'h0,    0, 32'h3,    0, 32'h0,    0};
    tbl[10] = '{1, 2, 0, 1, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    0,   1, 0, 0, 0, 32'h0,    1, 32'h90,   0, 32'h0,    0};
    tbl[11] = '{0, 0, 0, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    1,   2, 0, 0, 0, 32'h0,    1, 32'h0,    0, 32'h0,    1};
    tbl[12] = '{1, 3, 0, 0, 0, 32'h44,    2'b00, 0, 32'h0,    0, 32'h0,    2,   2, 0, 0, 0, 32'h0,    0, 32'h2,    0, 32'h0,    0};
    tbl[13] = '{1, 0, 9, 1, 0, 32'h77,    2'b01, 2, 32'h2000, 0, 32'h0,    3,   3, 0, 0, 0, 32'h0,    0, 32'h3,    0, 32'h0,    0};
    tbl[14] = '{0, 0, 0, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    3,   4, 0, 0, 0, 32'h0,    1, 32'h77,   0, 32'h0,    0};
    tbl[15] = '{1, 0, 4, 1, 0, 32'h99,    2'b00, 0, 32'h0,    0, 32'h0,    3,   4, 0, 0, 0, 32'h0,    1, 32'h77,   1, 32'h2000, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 32'h0,     2'b00, 0, 32'h0,    0, 32'h0,    3,   0, 0, 0, 0, 32'h0,    0, 32'h3,    0, 32'h0,    0};

    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("reset allocIdx", 32'(allocIdx), 32'd0);
    checkOutput("reset robFull", 32'(robFull), 32'd0);
    checkOutput("reset commitValid", 32'(commitValid), 32'd0);
    checkOutput("reset storeGo", 32'(storeGo), 32'd0);
    checkOutput("reset flush", 32'(flush), 32'd0);
    checkOutput("reset flushPc", flushPc, 32'd0);

    // ALU writeback/commit, mispredicted branch flush, correct branch, store, JALR flush.
    for (int r = 0; r < 17; r++) begin
      applyStimulus(tbl[r]);
      #1;
      checkOutput($sformatf("row%0d allocIdx", r), 32'(allocIdx), 32'(tbl[r].eIdx));
      checkOutput($sformatf("row%0d robFull", r), 32'(robFull), 32'(tbl[r].eFull));
      checkOutput($sformatf("row%0d commitValid", r), 32'(commitValid), 32'(tbl[r].eCv));
      if (tbl[r].eCv) begin
        checkOutput($sformatf("row%0d commitRd", r), 32'(commitRd), 32'(tbl[r].eCrd));
        checkOutput($sformatf("row%0d commitVal", r), commitVal, tbl[r].eCval);
      end
      checkOutput($sformatf("row%0d rs1Ready", r), 32'(rs1Ready), 32'(tbl[r].eRdy));
      checkOutput($sformatf("row%0d rs1Val", r), rs1Val, tbl[r].eRval);
      checkOutput($sformatf("row%0d flush", r), 32'(flush), 32'(tbl[r].eFlush));
      checkOutput($sformatf("row%0d flushPc", r), flushPc, tbl[r].eFpc);
      checkOutput($sformatf("row%0d storeGo", r), 32'(storeGo), 32'(tbl[r].eSgo));
      step();
    end

    // Fill all 16 entries with nothing ready.
    clearInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      allocValid = 1'b1; allocKind = 2'd0; allocRd = 5'd1; allocDone = 1'b0; allocVal = 32'd0;
      #1;
      checkOutput($sformatf("fill%0d allocIdx", i), 32'(allocIdx), 32'(i));
      checkOutput($sformatf("fill%0d robFull", i), 32'(robFull), (i == 15) ? 32'd1 : 32'd0);
      step();
    end
    #1;
    checkOutput("fill17 robFull", 32'(robFull), 32'd1);
    checkOutput("fill17 allocIdx", 32'(allocIdx), 32'd0);
    step();
    allocValid = 1'b0;
    setWb(0, 4'd0, 32'hAA);
    #1;
    checkOutput("full idle robFull", 32'(robFull), 32'd1);
    checkOutput("full after 17th allocIdx", 32'(allocIdx), 32'd0);
    step();
    wbValid = 2'b00;
    #1;
    checkOutput("full retire commitValid", 32'(commitValid), 32'd1);
    checkOutput("full retire commitVal", commitVal, 32'hAA);
    checkOutput("full retire robFull", 32'(robFull), 32'd1);
    step();
    setWb(1, 4'd1, 32'hBB);
    #1;
    checkOutput("depth-1 idle robFull", 32'(robFull), 32'd0);
    step();
    wbValid = 2'b00;
    allocValid = 1'b1;
    #1;
    checkOutput("alloc+retire robFull", 32'(robFull), 32'd0);
    checkOutput("alloc+retire commitValid", 32'(commitValid), 32'd1);
    checkOutput("alloc+retire commitVal", commitVal, 32'hBB);
    checkOutput("alloc+retire allocIdx", 32'(allocIdx), 32'd0);
    step();
    #1;
    checkOutput("count held robFull", 32'(robFull), 32'd1);
    checkOutput("count held allocIdx", 32'(allocIdx), 32'd1);
    checkOutput("count held commitIdx", 32'(commitIdx), 32'd2);
    allocValid = 1'b0;
    setWb(0, 4'd2, 32'h22);
    setWb(1, 4'd3, 32'h33);
    step();
    wbValid = 2'b00;
    rs1Idx = 4'd2;
    rs2Idx = 4'd3;
    #1;
    checkOutput("dual wb rs1Ready", 32'(rs1Ready), 32'd1);
    checkOutput("dual wb rs1Val", rs1Val, 32'h22);
    checkOutput("dual wb rs2Ready", 32'(rs2Ready), 32'd1);
    checkOutput("dual wb rs2Val", rs2Val, 32'h33);

    // Freeze with rdy low while a writeback is presented; it must not land.
    rdy = 1'b0;
    rs1Idx = 4'd4;
    setWb(0, 4'd4, 32'h44);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("freeze%0d allocIdx", c), 32'(allocIdx), 32'd1);
      checkOutput($sformatf("freeze%0d commitIdx", c), 32'(commitIdx), 32'd2);
`ifdef ROB_BYPASS_EN
      checkOutput($sformatf("freeze%0d bypass rs1Ready", c), 32'(rs1Ready), 32'd1);
      checkOutput($sformatf("freeze%0d bypass rs1Val", c), rs1Val, 32'h44);
`else
      checkOutput($sformatf("freeze%0d rs1Ready", c), 32'(rs1Ready), 32'd0);
      checkOutput($sformatf("freeze%0d rs1Val", c), rs1Val, 32'h4);
`endif
      step();
    end
    rdy = 1'b1;
    wbValid = 2'b00;
    #1;
    checkOutput("thaw rs1Ready", 32'(rs1Ready), 32'd0);
    checkOutput("thaw commitIdx", 32'(commitIdx), 32'd2);
    checkOutput("thaw commitValid", 32'(commitValid), 32'd1);
    step();
    #1;
    checkOutput("thaw retire commitIdx", 32'(commitIdx), 32'd3);
    checkOutput("thaw retire allocIdx", 32'(allocIdx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
